// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x DATA_WIDTH register file with one write port and
// two independent registered read ports; same-edge writes bypass to reads.
module regfile_2r1w #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ZERO_REG   = 0,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_err,
    input  logic                  rd1_en,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic [DATA_WIDTH-1:0] rd1_data,
    output logic                  rd1_valid,
    output logic                  rd1_err,
    input  logic                  rd2_en,
    input  logic [ADDR_WIDTH-1:0] rd2_addr,
    output logic [DATA_WIDTH-1:0] rd2_data,
    output logic                  rd2_valid,
    output logic                  rd2_err
);

    if (DATA_WIDTH < 8 || DATA_WIDTH > 32) begin : g_bad_width
        $error("regfile_2r1w: DATA_WIDTH must be 8..32");
    end
    if (DEPTH < 2 || DEPTH > 32) begin : g_bad_depth
        $error("regfile_2r1w: DEPTH must be 2..32");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rd1_data_q, rd1_data_d;
    logic [DATA_WIDTH-1:0] rd2_data_q, rd2_data_d;
    logic                  rd1_valid_q, rd1_valid_d;
    logic                  rd2_valid_q, rd2_valid_d;
    logic                  rd1_err_q, rd1_err_d;
    logic                  rd2_err_q, rd2_err_d;
    logic                  wr_err_q, wr_err_d;
    logic                  wr_ok;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Value a read port captures: out-of-range and hardwired zero give 0,
    // a landing write wins over the stored entry.
    function automatic logic [DATA_WIDTH-1:0] rd_value(
        input logic [ADDR_WIDTH-1:0] a
    );
        if (!in_range(a) || is_zero_reg(a)) begin
            return '0;
        end else if (wr_ok && wr_addr == a) begin
            return wr_data;
        end else begin
            return mem_q[a];
        end
    endfunction

    // Next state of storage, read ports and write error.
    always_comb begin
        wr_ok = wr_en && in_range(wr_addr) && !is_zero_reg(wr_addr);
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
        end
        wr_err_d = wr_en && !in_range(wr_addr);

        rd1_valid_d = rd1_en;
        rd1_err_d   = rd1_en && !in_range(rd1_addr);
        rd1_data_d  = rd1_en ? rd_value(rd1_addr) : rd1_data_q;

        rd2_valid_d = rd2_en;
        rd2_err_d   = rd2_en && !in_range(rd2_addr);
        rd2_data_d  = rd2_en ? rd_value(rd2_addr) : rd2_data_q;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd1_data_q  <= '0;
            rd2_data_q  <= '0;
            rd1_valid_q <= 1'b0;
            rd2_valid_q <= 1'b0;
            rd1_err_q   <= 1'b0;
            rd2_err_q   <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            rd1_data_q  <= rd1_data_d;
            rd2_data_q  <= rd2_data_d;
            rd1_valid_q <= rd1_valid_d;
            rd2_valid_q <= rd2_valid_d;
            rd1_err_q   <= rd1_err_d;
            rd2_err_q   <= rd2_err_d;
            wr_err_q    <= wr_err_d;
        end
    end

    assign rd1_data  = rd1_data_q;
    assign rd2_data  = rd2_data_q;
    assign rd1_valid = rd1_valid_q;
    assign rd2_valid = rd2_valid_q;
    assign rd1_err   = rd1_err_q;
    assign rd2_err   = rd2_err_q;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: two configurations (8x8 plain, 6x32 with zero reg)
// checked against an array-based model of the register file.
module tb_regfile_2r1w;

    logic clk;
    logic reset_n;

    // Instance A: DATA_WIDTH=8, DEPTH=8, ZERO_REG=0
    logic       a_wr_en, a_rd1_en, a_rd2_en;
    logic [2:0] a_wr_addr, a_rd1_addr, a_rd2_addr;
    logic [7:0] a_wr_data, a_rd1_data, a_rd2_data;
    logic       a_wr_err, a_rd1_valid, a_rd2_valid, a_rd1_err, a_rd2_err;

    // Instance B: DATA_WIDTH=32, DEPTH=6, ZERO_REG=1
    logic        b_wr_en, b_rd1_en, b_rd2_en;
    logic [2:0]  b_wr_addr, b_rd1_addr, b_rd2_addr;
    logic [31:0] b_wr_data, b_rd1_data, b_rd2_data;
    logic        b_wr_err, b_rd1_valid, b_rd2_valid, b_rd1_err, b_rd2_err;

    regfile_2r1w #(.DATA_WIDTH(8), .DEPTH(8), .ZERO_REG(0)) u_a (
        .clk(clk), .reset_n(reset_n),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .wr_err(a_wr_err),
        .rd1_en(a_rd1_en), .rd1_addr(a_rd1_addr), .rd1_data(a_rd1_data),
        .rd1_valid(a_rd1_valid), .rd1_err(a_rd1_err),
        .rd2_en(a_rd2_en), .rd2_addr(a_rd2_addr), .rd2_data(a_rd2_data),
        .rd2_valid(a_rd2_valid), .rd2_err(a_rd2_err)
    );

    regfile_2r1w #(.DATA_WIDTH(32), .DEPTH(6), .ZERO_REG(1)) u_b (
        .clk(clk), .reset_n(reset_n),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .wr_err(b_wr_err),
        .rd1_en(b_rd1_en), .rd1_addr(b_rd1_addr), .rd1_data(b_rd1_data),
        .rd1_valid(b_rd1_valid), .rd1_err(b_rd1_err),
        .rd2_en(b_rd2_en), .rd2_addr(b_rd2_addr), .rd2_data(b_rd2_data),
        .rd2_valid(b_rd2_valid), .rd2_err(b_rd2_err)
    );

    int n_chk;
    int n_fail;

    // Reference state: storage arrays and expected output registers.
    logic [7:0]  ma [8];
    logic [31:0] mb [6];
    logic [7:0]  ea_d1, ea_d2;
    logic        ea_v1, ea_v2, ea_e1, ea_e2, ea_we;
    logic [31:0] eb_d1, eb_d2;
    logic        eb_v1, eb_v2, eb_e1, eb_e2, eb_we;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic model_clear();
        for (int i = 0; i < 8; i++) ma[i] = '0;
        for (int i = 0; i < 6; i++) mb[i] = '0;
        ea_d1 = '0; ea_d2 = '0; ea_v1 = 0; ea_v2 = 0;
        ea_e1 = 0; ea_e2 = 0; ea_we = 0;
        eb_d1 = '0; eb_d2 = '0; eb_v1 = 0; eb_v2 = 0;
        eb_e1 = 0; eb_e2 = 0; eb_we = 0;
    endtask

    // 8 entries, all addresses legal, no zero register.
    task automatic model_a();
        logic [7:0] nxt [8];
        nxt = ma;
        if (a_wr_en) nxt[a_wr_addr] = a_wr_data;
        ea_we = 1'b0;
        ea_v1 = a_rd1_en; ea_e1 = 1'b0;
        ea_v2 = a_rd2_en; ea_e2 = 1'b0;
        if (a_rd1_en) ea_d1 = nxt[a_rd1_addr];
        if (a_rd2_en) ea_d2 = nxt[a_rd2_addr];
        ma = nxt;
    endtask

    // 6 entries, entry 0 reads as zero, addresses 6 and 7 are errors.
    task automatic model_b();
        logic [31:0] nxt [6];
        nxt = mb;
        if (b_wr_en && b_wr_addr < 6 && b_wr_addr != 0)
            nxt[b_wr_addr] = b_wr_data;
        eb_we = b_wr_en && b_wr_addr >= 6;
        eb_v1 = b_rd1_en; eb_e1 = b_rd1_en && b_rd1_addr >= 6;
        eb_v2 = b_rd2_en; eb_e2 = b_rd2_en && b_rd2_addr >= 6;
        if (b_rd1_en) eb_d1 = (b_rd1_addr < 6) ? nxt[b_rd1_addr] : '0;
        if (b_rd2_en) eb_d2 = (b_rd2_addr < 6) ? nxt[b_rd2_addr] : '0;
        mb = nxt;
    endtask

    task automatic idle();
        a_wr_en = 0; a_rd1_en = 0; a_rd2_en = 0;
        b_wr_en = 0; b_rd1_en = 0; b_rd2_en = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) begin
            model_a();
            model_b();
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        a_wr_addr = '0; a_wr_data = '0; a_rd1_addr = '0; a_rd2_addr = '0;
        b_wr_addr = '0; b_wr_data = '0; b_rd1_addr = '0; b_rd2_addr = '0;
        reset_n = 1'b0;
        model_clear();
        repeat (2) tick();
        n_chk++;
        if ({a_rd1_data, a_rd2_data, a_rd1_valid, a_rd2_valid,
             a_rd1_err, a_rd2_err, a_wr_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_a outputs got %h/%h v%b%b e%b%b w%b",
                     a_rd1_data, a_rd2_data, a_rd1_valid, a_rd2_valid,
                     a_rd1_err, a_rd2_err, a_wr_err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_rd1_en = 1; a_rd1_addr = 3'(i);
            a_rd2_en = 1; a_rd2_addr = 3'(7 - i);
            tick();
            n_chk++;
            if (a_rd1_data !== 8'h00 || a_rd2_data !== 8'h00
                || a_rd1_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_read addr %0d got %h/%h v%b want 00/00 v1",
                         i, a_rd1_data, a_rd2_data, a_rd1_valid);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_basic();
        a_wr_en = 1; a_wr_addr = 3; a_wr_data = 8'hA5;
        tick();
        idle();
        a_rd1_en = 1; a_rd1_addr = 3;
        tick();
        n_chk++;
        if (a_rd1_data !== 8'hA5 || a_rd1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_read got %h v%b want a5 v1",
                     a_rd1_data, a_rd1_valid);
        end
        idle();
        tick();
        n_chk++;
        if (a_rd1_data !== 8'hA5 || a_rd1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_hold got %h v%b want a5 v0",
                     a_rd1_data, a_rd1_valid);
        end
    endtask

    task automatic test_write_priority();
        a_wr_en = 1; a_wr_addr = 5; a_wr_data = 8'h11;
        tick();
        a_wr_data = 8'h22;
        a_rd1_en = 1; a_rd1_addr = 5;
        a_rd2_en = 1; a_rd2_addr = 5;
        tick();
        n_chk++;
        if (a_rd1_data !== 8'h22 || a_rd2_data !== 8'h22) begin
            n_fail++;
            $display("FAIL bypass got %h/%h want 22/22",
                     a_rd1_data, a_rd2_data);
        end
        idle();
        a_rd2_en = 1; a_rd2_addr = 5;
        tick();
        n_chk++;
        if (a_rd2_data !== 8'h22) begin
            n_fail++;
            $display("FAIL bypass_stored got %h want 22", a_rd2_data);
        end
        idle();
    endtask

    task automatic test_dual_read();
        b_wr_en = 1; b_wr_addr = 1; b_wr_data = 32'hDEADBEEF;
        tick();
        b_wr_addr = 2; b_wr_data = 32'h12345678;
        tick();
        idle();
        b_rd1_en = 1; b_rd1_addr = 1;
        b_rd2_en = 1; b_rd2_addr = 2;
        tick();
        n_chk++;
        if (b_rd1_data !== 32'hDEADBEEF || b_rd2_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL dual_read got %h/%h want deadbeef/12345678",
                     b_rd1_data, b_rd2_data);
        end
        idle();
    endtask

    task automatic test_range_zero();
        b_wr_en = 1; b_wr_addr = 0; b_wr_data = 32'hFF;
        b_rd1_en = 1; b_rd1_addr = 0;
        tick();
        n_chk++;
        if (b_rd1_data !== 32'h0 || b_rd1_err !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_bypass got %h e%b want 0 e0",
                     b_rd1_data, b_rd1_err);
        end
        idle();
        b_rd1_en = 1; b_rd1_addr = 0;
        tick();
        n_chk++;
        if (b_rd1_data !== 32'h0 || b_rd1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_read got %h v%b want 0 v1",
                     b_rd1_data, b_rd1_valid);
        end
        idle();
        b_wr_en = 1; b_wr_addr = 7; b_wr_data = 32'hCAFE0007;
        tick();
        n_chk++;
        if (b_wr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_err_pulse got %b want 1", b_wr_err);
        end
        idle();
        tick();
        n_chk++;
        if (b_wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_err_clear got %b want 0", b_wr_err);
        end
        for (int i = 1; i < 6; i++) begin
            b_rd2_en = 1; b_rd2_addr = 3'(i);
            tick();
            n_chk++;
            if (b_rd2_data !== mb[i]) begin
                n_fail++;
                $display("FAIL oor_write_no_change addr %0d got %h want %h",
                         i, b_rd2_data, mb[i]);
            end
        end
        idle();
        b_rd1_en = 1; b_rd1_addr = 6;
        tick();
        n_chk++;
        if (b_rd1_data !== 32'h0 || b_rd1_err !== 1'b1
            || b_rd1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_read got %h e%b v%b want 0 e1 v1",
                     b_rd1_data, b_rd1_err, b_rd1_valid);
        end
        idle();
        tick();
        n_chk++;
        if (b_rd1_err !== 1'b0 || b_rd1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_read_clear e%b v%b want e0 v0",
                     b_rd1_err, b_rd1_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            a_wr_en = 1'($urandom); a_wr_addr = 3'($urandom);
            a_wr_data = 8'($urandom);
            a_rd1_en = 1'($urandom); a_rd1_addr = 3'($urandom);
            a_rd2_en = 1'($urandom); a_rd2_addr = 3'($urandom);
            b_wr_en = 1'($urandom); b_wr_addr = 3'($urandom);
            b_wr_data = $urandom;
            b_rd1_en = 1'($urandom); b_rd1_addr = 3'($urandom);
            b_rd2_en = 1'($urandom); b_rd2_addr = 3'($urandom);
            if ($urandom_range(0, 3) == 0) b_rd1_addr = b_wr_addr;
            if ($urandom_range(0, 3) == 0) a_rd2_addr = a_wr_addr;
            tick();
            n_chk++;
            if ({a_rd1_data, a_rd2_data, a_rd1_valid, a_rd2_valid,
                 a_rd1_err, a_rd2_err, a_wr_err}
                !== {ea_d1, ea_d2, ea_v1, ea_v2, ea_e1, ea_e2, ea_we}) begin
                n_fail++;
                $display("FAIL rand_a cyc %0d got %h/%h v%b%b e%b%b w%b want %h/%h v%b%b e%b%b w%b",
                         c, a_rd1_data, a_rd2_data, a_rd1_valid, a_rd2_valid,
                         a_rd1_err, a_rd2_err, a_wr_err, ea_d1, ea_d2,
                         ea_v1, ea_v2, ea_e1, ea_e2, ea_we);
            end
            n_chk++;
            if ({b_rd1_data, b_rd2_data, b_rd1_valid, b_rd2_valid,
                 b_rd1_err, b_rd2_err, b_wr_err}
                !== {eb_d1, eb_d2, eb_v1, eb_v2, eb_e1, eb_e2, eb_we}) begin
                n_fail++;
                $display("FAIL rand_b cyc %0d got %h/%h v%b%b e%b%b w%b want %h/%h v%b%b e%b%b w%b",
                         c, b_rd1_data, b_rd2_data, b_rd1_valid, b_rd2_valid,
                         b_rd1_err, b_rd2_err, b_wr_err, eb_d1, eb_d2,
                         eb_v1, eb_v2, eb_e1, eb_e2, eb_we);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        a_wr_en = 1; a_wr_addr = 4; a_wr_data = 8'h77;
        a_rd1_en = 1; a_rd1_addr = 4;
        b_wr_en = 1; b_wr_addr = 7;
        b_rd1_en = 1; b_rd1_addr = 6;
        tick();
        a_wr_data = 8'h77;
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        n_chk++;
        if ({a_rd1_data, a_rd2_data, a_rd1_valid, a_rd2_valid,
             a_rd1_err, a_rd2_err, a_wr_err} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_a got %h/%h v%b%b e%b%b w%b want all 0",
                     a_rd1_data, a_rd2_data, a_rd1_valid, a_rd2_valid,
                     a_rd1_err, a_rd2_err, a_wr_err);
        end
        n_chk++;
        if ({b_rd1_data, b_rd2_data, b_rd1_valid, b_rd2_valid,
             b_rd1_err, b_rd2_err, b_wr_err} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_b got %h/%h v%b%b e%b%b w%b want all 0",
                     b_rd1_data, b_rd2_data, b_rd1_valid, b_rd2_valid,
                     b_rd1_err, b_rd2_err, b_wr_err);
        end
        tick();
        n_chk++;
        if (a_rd1_valid !== 1'b0 || b_wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held got v%b w%b want v0 w0",
                     a_rd1_valid, b_wr_err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        a_rd1_en = 1; a_rd1_addr = 4;
        tick();
        n_chk++;
        if (a_rd1_data !== 8'h00 || a_rd1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lost_write got %h v%b want 00 v1",
                     a_rd1_data, a_rd1_valid);
        end
        idle();
        tick();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_write_priority();
        test_dual_read();
        test_range_zero();
        test_random();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised register file; successor to the team's single read/write-port register.
- Provides DEPTH entries of DATA_WIDTH bits, one write port and two independent read ports.
- Write takes priority over read: a same-cycle read of the entry being written returns the new data.
- Sits in the custom processor datapath between decode (register addresses) and execute (operands), with write-back from the final stage.

Parameters:
- DATA_WIDTH, 8, entry width in bits; legal range 8..32; any other value is an elaboration error.
- DEPTH, 8, number of entries; legal range 2..32; need not be a power of two.
- ZERO_REG, 0, when 1 entry 0 is hardwired to zero and writes to it are discarded.
- ADDR_WIDTH (localparam), $clog2(DEPTH), address width; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request for this cycle.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- wr_err  output  1  registered; pulses for one cycle after a write to an address >= DEPTH.
- rd1_en  input  1  read port 1 request.
- rd1_addr  input  ADDR_WIDTH  read port 1 address.
- rd1_data  output  DATA_WIDTH  registered read port 1 data.
- rd1_valid  output  1  rd1_data was updated by a request on the previous edge.
- rd1_err  output  1  the read port 1 request was out of range.
- rd2_en, rd2_addr, rd2_data, rd2_valid, rd2_err: identical to port 1, fully independent.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately regardless of clk):
  - all entries 0;
  - rd1_data, rd2_data = 0;
  - rd1_valid, rd2_valid, rd1_err, rd2_err, wr_err = 0.
  - Remains in effect while low. No operation is performed on a clk edge while reset_n is low. A write or read in flight when reset asserts is lost.
- Write:
  - On posedge clk with wr_en=1 and wr_addr < DEPTH, mem[wr_addr] <= wr_data.
  - Discarded, with no state change, if ZERO_REG=1 and wr_addr=0.
  - wr_addr >= DEPTH: no state change; wr_err=1 for the following cycle.
  - wr_err=0 on any edge without an out-of-range write.
- Read (per port N, 1-cycle latency):
  - On posedge clk with rdN_en=1:
    - rdN_valid <= 1.
    - addr >= DEPTH: rdN_data <= 0, rdN_err <= 1.
    - ZERO_REG=1 and addr=0: rdN_data <= 0, rdN_err <= 0.
    - else if wr_en=1, wr_addr == rdN_addr and the write is not discarded: rdN_data <= wr_data (write-priority bypass), rdN_err <= 0.
    - else rdN_data <= mem[rdN_addr], rdN_err <= 0.
  - With rdN_en=0: rdN_data holds its last value (never tri-stated); rdN_valid <= 0; rdN_err <= 0.
- Simultaneous events:
  - Both read ports may target the same address, including the write address; both receive bypassed data.
  - Write and reads on the same edge are always permitted; no stall, no back-pressure.
- Storage holds state indefinitely without enables; no read side effects.
- Outputs are driven only from flops; no combinational path from inputs to outputs.

Test Plan:
- Reset: DATA_WIDTH=8, DEPTH=8. Assert reset_n=0 mid-cycle -> all rd outputs and err/valid go 0 without waiting for clk. After release, reading every address returns 0x00.
- Basic write/read: write 0xA5 to addr 3 on edge k. rd1_en, addr 3 on edge k+1 -> rd1_data=0xA5, rd1_valid=1 after edge k+1. With rd1_en=0 on edge k+2 -> rd1_data stays 0xA5, rd1_valid=0.
- Write priority: mem[5]=0x11. On one edge, wr_en with addr 5 data 0x22, plus rd1 and rd2 both on addr 5 -> both rd data=0x22 after that edge; mem[5]=0x22 afterwards.
- Dual independent read: DATA_WIDTH=32, mem[1]=0xDEADBEEF, mem[2]=0x12345678. rd1 addr 1 and rd2 addr 2 on the same edge -> outputs 0xDEADBEEF and 0x12345678.
- Range/zero: DEPTH=6, ZERO_REG=1. Write 0xFF to addr 0 -> reads back 0x00. Write to addr 7 -> wr_err=1 for one cycle, no entry changes. Read addr 6 -> rd1_data=0, rd1_err=1, rd1_valid=1.
- Reset mid-operation: wr_en to addr 4 with 0x77 while reset_n falls before the edge -> after release, addr 4 reads 0x00.
